sprite_line_scheduler: RTL and testbench

Per-scanline sprite compositor that shares the three sprite frame RAMs (frog 28x28, car 56x28, log 112x28; 5-bit palette indices, asynchronous read) among up to NUM_OBJ game objects. On each line_start it clears a one-line buffer, then walks the object table in index order. For every object that covers the requested line, it reads that sprite row and writes the non-transparent pixels into the line buffer. The VGA color mapper reads the buffer on the following scanline.

---
 rtl/sprite_line_scheduler_if.sv | 32 +++
 rtl/sprite_line_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scheduler_if.sv
// Object-table, sprite-RAM and line-buffer signals shared between the
// scanline compositor (master) and its memories/object table (slave).
interface sprite_line_scheduler_if #(
    parameter int unsigned NUM_OBJ = 8
);
    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic [IDX_W-1:0] obj_idx;
    logic             obj_valid;
    logic [1:0]       obj_type;
    logic [10:0]      obj_x;
    logic [9:0]       obj_y;

    logic [18:0]      spr_addr;
    logic [4:0]       frog_data;
    logic [4:0]       car_data;
    logic [4:0]       log_data;

    logic             lb_we;
    logic [9:0]       lb_addr;
    logic [4:0]       lb_data;

    modport master (
        output obj_idx, spr_addr, lb_we, lb_addr, lb_data,
        input  obj_valid, obj_type, obj_x, obj_y, frog_data, car_data, log_data
    );

    modport slave (
        input  obj_idx, spr_addr, lb_we, lb_addr, lb_data,
        output obj_valid, obj_type, obj_x, obj_y, frog_data, car_data, log_data
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite compositor: clears a line buffer, then draws every object
// covering the requested line in table order so higher indices win.
module sprite_line_scheduler #(
    parameter int unsigned NUM_OBJ = 8,
    parameter int unsigned LINE_W  = 640,
    parameter int unsigned SPR_H   = 28,
    parameter int unsigned FROG_W  = 28,
    parameter int unsigned CAR_W   = 56,
    parameter int unsigned LOG_W   = 112,
    parameter logic [4:0]  TRANSP  = 5'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       line_start,
    input  logic [9:0] line_y,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    sprite_line_scheduler_if.master bus
);
    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        EVAL  = 3'd2,
        DRAW  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       line_y_q, line_y_d;
    logic [9:0]       col_q, col_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       type_q, type_d;
    logic [10:0]      x_q, x_d;
    logic [11:0]      base_q, base_d;
    logic             lb_we_q, lb_we_d;
    logic [9:0]       lb_addr_q, lb_addr_d;
    logic [4:0]       lb_data_q, lb_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic [9:0]         row;
    logic               hit;
    logic [9:0]         w_eval;
    logic [9:0]         w_draw;
    logic               last_obj;
    logic [4:0]         pix;
    logic signed [11:0] px;
    logic               px_ok;
    logic               accept;

    function automatic logic [9:0] spr_w(input logic [1:0] t);
        case (t)
            2'd0:    return 10'(FROG_W);
            2'd1:    return 10'(CAR_W);
            default: return 10'(LOG_W);
        endcase
    endfunction

    // Row within the sprite wraps modulo 2^10, so lines above an object miss.
    assign row      = line_y_q - bus.obj_y;
    assign hit      = bus.obj_valid && (bus.obj_type != 2'd3) && (row < 10'(SPR_H));
    assign w_eval   = spr_w(bus.obj_type);
    assign w_draw   = spr_w(type_q);
    assign last_obj = (idx_q == IDX_W'(NUM_OBJ - 1));

    always_comb begin
        pix = TRANSP;
        case (type_q)
            2'd0:    pix = bus.frog_data;
            2'd1:    pix = bus.car_data;
            2'd2:    pix = bus.log_data;
            default: pix = TRANSP;
        endcase
    end

    assign px     = $signed({x_q[10], x_q}) + $signed({2'b00, col_q});
    assign px_ok  = !px[11] && (px[10:0] < 11'(LINE_W));
    // The done cycle still counts as finishing; new lines start only after it.
    assign accept = (state_q == IDLE) && !done_q;

    assign bus.spr_addr = (state_q == DRAW) ? (19'(base_q) + 19'(col_q)) : 19'd0;
    assign bus.obj_idx  = idx_q;
    assign bus.lb_we    = lb_we_q;
    assign bus.lb_addr  = lb_addr_q;
    assign bus.lb_data  = lb_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        line_y_d  = line_y_q;
        col_d     = col_q;
        idx_d     = idx_q;
        type_d    = type_q;
        x_d       = x_q;
        base_d    = base_q;
        lb_we_d   = 1'b0;
        lb_addr_d = lb_addr_q;
        lb_data_d = lb_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        if (line_start && !accept) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (line_start && accept) begin
                    line_y_d = line_y;
                    col_d    = 10'd0;
                    busy_d   = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                lb_we_d   = 1'b1;
                lb_addr_d = col_q;
                lb_data_d = TRANSP;
                if (col_q == 10'(LINE_W - 1)) begin
                    idx_d   = '0;
                    state_d = EVAL;
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            EVAL: begin
                if (hit) begin
                    type_d  = bus.obj_type;
                    x_d     = bus.obj_x;
                    base_d  = 12'(row) * 12'(w_eval);
                    col_d   = 10'd0;
                    state_d = DRAW;
                end else if (last_obj) begin
                    state_d = FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAW: begin
                if ((pix != TRANSP) && px_ok) begin
                    lb_we_d   = 1'b1;
                    lb_addr_d = px[9:0];
                    lb_data_d = pix;
                end
                if (col_q == w_draw - 10'd1) begin
                    if (last_obj) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = EVAL;
                    end
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            line_y_q  <= 10'd0;
            col_q     <= 10'd0;
            idx_q     <= '0;
            type_q    <= 2'd0;
            x_q       <= 11'd0;
            base_q    <= 12'd0;
            lb_we_q   <= 1'b0;
            lb_addr_q <= 10'd0;
            lb_data_q <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_y_q  <= line_y_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            type_q    <= type_d;
            x_q       <= x_d;
            base_q    <= base_d;
            lb_we_q   <= lb_we_d;
            lb_addr_q <= lb_addr_d;
            lb_data_q <= lb_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: expected line-buffer writes and
// sprite addresses are queued at line_start and popped as the DUT emits them.
module tb_sprite_line_scheduler;
    localparam int unsigned NUM_OBJ = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       line_start = 1'b0;
    logic [9:0] line_y = 10'd0;
    logic       busy, done, overrun;

    sprite_line_scheduler_if #(.NUM_OBJ(NUM_OBJ)) bus ();

    sprite_line_scheduler #(.NUM_OBJ(NUM_OBJ)) dut (
        .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
        .busy(busy), .done(done), .overrun(overrun), .bus(bus)
    );

    always #5 Clk = ~Clk;

    logic        tbl_valid [NUM_OBJ];
    logic [1:0]  tbl_type  [NUM_OBJ];
    logic [10:0] tbl_x     [NUM_OBJ];
    logic [9:0]  tbl_y     [NUM_OBJ];

    // Sprite contents: deterministic pattern with some transparent (0) pixels.
    function automatic logic [4:0] spr_px(input int t, input int addr);
        return 5'((addr * (3 + 2 * t) + 5 * t + 1) % 32);
    endfunction

    function automatic int obj_w(input logic [1:0] t);
        return (t == 2'd0) ? 28 : (t == 2'd1) ? 56 : 112;
    endfunction

    assign bus.obj_valid = tbl_valid[bus.obj_idx];
    assign bus.obj_type  = tbl_type[bus.obj_idx];
    assign bus.obj_x     = tbl_x[bus.obj_idx];
    assign bus.obj_y     = tbl_y[bus.obj_idx];
    assign bus.frog_data = spr_px(0, int'(bus.spr_addr));
    assign bus.car_data  = spr_px(1, int'(bus.spr_addr));
    assign bus.log_data  = spr_px(2, int'(bus.spr_addr));

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          wr_count = 0;
    logic [14:0] exp_wr [$];
    logic [18:0] exp_spr [$];
    logic [4:0]  lb_mem [1024];

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard on every buffer write and sprite fetch.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.lb_we) begin
                logic [14:0] e;
                wr_count++;
                lb_mem[bus.lb_addr] = bus.lb_data;
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL lb_write: unexpected write addr=%0d data=%0d", bus.lb_addr, bus.lb_data);
                end else begin
                    e = exp_wr.pop_front();
                    if ({bus.lb_addr, bus.lb_data} !== e) begin
                        miscompares++;
                        $display("FAIL lb_write: got addr=%0d data=%0d want addr=%0d data=%0d",
                                 bus.lb_addr, bus.lb_data, e[14:5], e[4:0]);
                    end
                end
            end
            if (bus.spr_addr != 19'd0) begin
                logic [18:0] s;
                vectors++;
                if (exp_spr.size() == 0) begin
                    miscompares++;
                    $display("FAIL spr_addr: unexpected fetch %0d", bus.spr_addr);
                end else begin
                    s = exp_spr.pop_front();
                    if (bus.spr_addr !== s) begin
                        miscompares++;
                        $display("FAIL spr_addr: got %0d want %0d", bus.spr_addr, s);
                    end
                end
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < NUM_OBJ; i++) begin
            tbl_valid[i] = 1'b0;
            tbl_type[i]  = 2'd0;
            tbl_x[i]     = 11'd0;
            tbl_y[i]     = 10'd0;
        end
    endtask

    task automatic set_obj(input int i, input logic [1:0] t, input int x, input int y);
        tbl_valid[i] = 1'b1;
        tbl_type[i]  = t;
        tbl_x[i]     = 11'(x);
        tbl_y[i]     = 10'(y);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        line_start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        exp_wr.delete();
        exp_spr.delete();
        wr_count = 0;
    endtask

    // Push the expected write/fetch stream, then pulse line_start.
    task automatic start_line(input logic [9:0] y, output int hit_w, output int n_exp);
        hit_w = 0;
        for (int i = 0; i < 640; i++) exp_wr.push_back({10'(i), 5'h00});
        for (int o = 0; o < NUM_OBJ; o++) begin
            logic [9:0] row;
            row = y - tbl_y[o];
            if (tbl_valid[o] && tbl_type[o] != 2'd3 && row < 10'd28) begin
                int w;
                int xs;
                w  = obj_w(tbl_type[o]);
                xs = int'($signed(tbl_x[o]));
                hit_w += w;
                for (int c = 0; c < w; c++) begin
                    int addr;
                    int p;
                    logic [4:0] d;
                    addr = int'(row) * w + c;
                    d = spr_px(int'(tbl_type[o]), addr);
                    p = xs + c;
                    if (addr != 0) exp_spr.push_back(19'(addr));
                    if (d != 5'd0 && p >= 0 && p < 640) exp_wr.push_back({10'(p), d});
                end
            end
        end
        n_exp = exp_wr.size();
        wr_count = 0;
        @(negedge Clk);
        line_y = y;
        line_start = 1'b1;
        t0 = cyc;
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, done, overrun, bus.lb_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, overrun, bus.lb_we});
        end
        vectors++;
        if (bus.lb_addr !== 10'd0 || bus.lb_data !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_lb: got addr=%0d data=%0d want 0 0", bus.lb_addr, bus.lb_data);
        end
        vectors++;
        if (bus.obj_idx !== 3'd0 || bus.spr_addr !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_idx: got idx=%0d spr=%0d want 0 0", bus.obj_idx, bus.spr_addr);
        end
    endtask

    task automatic test_empty();
        int hw, ne, lat;
        clear_table();
        start_line(10'd100, hw, ne);
        wait_done(lat);
        vectors++;
        if (lat !== 650) begin
            miscompares++;
            $display("FAIL empty_latency: got %0d want 650", lat);
        end
        vectors++;
        if (wr_count !== 640) begin
            miscompares++;
            $display("FAIL empty_writes: got %0d want 640", wr_count);
        end
        @(negedge Clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_frog();
        int hw, ne, lat;
        clear_table();
        set_obj(7, 2'd0, 10, 90);
        start_line(10'd95, hw, ne);
        wait_done(lat);
        vectors++;
        if (lat !== 650 + 28) begin
            miscompares++;
            $display("FAIL frog_latency: got %0d want %0d", lat, 650 + 28);
        end
        vectors++;
        if (exp_wr.size() != 0 || exp_spr.size() != 0 || wr_count != ne) begin
            miscompares++;
            $display("FAIL frog_stream: got writes=%0d left=%0d/%0d want writes=%0d left=0/0",
                     wr_count, exp_wr.size(), exp_spr.size(), ne);
        end
        vectors++;
        if (lb_mem[10] !== spr_px(0, 140) || lb_mem[38] !== 5'd0) begin
            miscompares++;
            $display("FAIL frog_buffer: got [10]=%0d [38]=%0d want %0d 0", lb_mem[10], lb_mem[38], spr_px(0, 140));
        end
    endtask

    task automatic test_priority();
        int hw, ne, lat;
        clear_table();
        set_obj(0, 2'd1, 180, 50);
        set_obj(3, 2'd2, 150, 50);
        start_line(10'd60, hw, ne);
        wait_done(lat);
        vectors++;
        if (lat !== 650 + 56 + 112) begin
            miscompares++;
            $display("FAIL prio_latency: got %0d want %0d", lat, 650 + 56 + 112);
        end
        vectors++;
        if (lb_mem[200] !== spr_px(2, 10 * 112 + 50)) begin
            miscompares++;
            $display("FAIL prio_overlap: got %0d want %0d", lb_mem[200], spr_px(2, 10 * 112 + 50));
        end
        vectors++;
        if (exp_wr.size() != 0 || wr_count != ne) begin
            miscompares++;
            $display("FAIL prio_stream: got writes=%0d left=%0d want writes=%0d left=0", wr_count, exp_wr.size(), ne);
        end
    endtask

    task automatic test_clip();
        int hw, ne, lat;
        clear_table();
        set_obj(1, 2'd2, -50, 200);
        set_obj(2, 2'd1, 600, 200);
        start_line(10'd227, hw, ne);
        wait_done(lat);
        vectors++;
        if (lat !== 650 + 168) begin
            miscompares++;
            $display("FAIL clip_latency: got %0d want %0d", lat, 650 + 168);
        end
        vectors++;
        if (exp_wr.size() != 0 || exp_spr.size() != 0 || wr_count != ne) begin
            miscompares++;
            $display("FAIL clip_stream: got writes=%0d left=%0d/%0d want writes=%0d left=0/0",
                     wr_count, exp_wr.size(), exp_spr.size(), ne);
        end
    endtask

    task automatic test_skip();
        int hw, ne, lat;
        clear_table();
        set_obj(2, 2'd0, 100, 20);
        set_obj(4, 2'd3, 0, 19);
        start_line(10'd19, hw, ne);
        wait_done(lat);
        vectors++;
        if (lat !== 650) begin
            miscompares++;
            $display("FAIL skip_latency: got %0d want 650", lat);
        end
        vectors++;
        if (wr_count !== 640) begin
            miscompares++;
            $display("FAIL skip_writes: got %0d want 640", wr_count);
        end
    endtask

    task automatic test_overrun();
        int hw, ne, lat;
        do_reset();
        clear_table();
        start_line(10'd100, hw, ne);
        repeat (100) @(negedge Clk);
        line_y = 10'd5;
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got overrun=%b busy=%b want 1 1", overrun, busy);
        end
        wait_done(lat);
        vectors++;
        if (lat !== 650 || wr_count !== 640) begin
            miscompares++;
            $display("FAIL overrun_timing: got lat=%0d writes=%0d want 650 640", lat, wr_count);
        end
    endtask

    task automatic test_done_collision();
        int hw, ne, lat;
        do_reset();
        clear_table();
        start_line(10'd100, hw, ne);
        wait_done(lat);
        line_y = 10'd7;
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL done_collision: got busy=%b overrun=%b want 0 1", busy, overrun);
        end
        repeat (5) @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || wr_count !== 640) begin
            miscompares++;
            $display("FAIL done_collision_idle: got busy=%b writes=%0d want 0 640", busy, wr_count);
        end
    endtask

    task automatic test_reset_mid();
        int hw, ne;
        bit seen;
        do_reset();
        clear_table();
        set_obj(7, 2'd0, 10, 90);
        start_line(10'd95, hw, ne);
        repeat (20) @(negedge Clk);
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.spr_addr != 19'd0) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        vectors++;
        if (!seen || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_reach: got draw_seen=%0d overrun=%b want 1 1", seen, overrun);
        end
        Reset = 1'b1;
        @(negedge Clk);
        vectors++;
        if ({bus.lb_we, busy, overrun, done} !== 4'b0000 || bus.spr_addr !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_state: got we/busy/ovr/done=%b spr=%0d want 0000 0",
                     {bus.lb_we, busy, overrun, done}, bus.spr_addr);
        end
        Reset = 1'b0;
        exp_wr.delete();
        exp_spr.delete();
    endtask

    initial begin
        clear_table();
        test_reset();
        test_empty();
        test_frog();
        test_priority();
        test_clip();
        test_skip();
        test_overrun();
        test_done_collision();
        test_reset_mid();
        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
